// File: rtl/pipeline_scoreboard_bypass.sv
// Register scoreboard with operand bypass: counts outstanding writes per register,
// stalls issue on unresolved RAW hazards and forwards results from NUM_FWD taps.
module pipeline_scoreboard_bypass #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned NUM_FWD     = 2,
    parameter int unsigned CNT_WIDTH   = 2,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [ADDR_WIDTH-1:0]         src1_addr,
    input  logic                          src1_used,
    input  logic [ADDR_WIDTH-1:0]         src2_addr,
    input  logic                          src2_used,
    input  logic [ADDR_WIDTH-1:0]         dst_addr,
    input  logic                          dst_used,
    input  logic [DATA_WIDTH-1:0]         rf_src1_value,
    input  logic [DATA_WIDTH-1:0]         rf_src2_value,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*ADDR_WIDTH-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data,
    input  logic                          commit_valid,
    input  logic [ADDR_WIDTH-1:0]         commit_addr,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         src1_value,
    output logic [DATA_WIDTH-1:0]         src2_value,
    output logic [2**ADDR_WIDTH-1:0]      pending_mask,
    output logic [STALL_CNT_W-1:0]        stall_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
    logic                  hit1, hit2;
    logic [DATA_WIDTH-1:0] fwd1, fwd2;
    logic [CNT_WIDTH-1:0]  cnt1, cnt2;
    logic                  hazard1, hazard2, full, accept;

    // Scan from the oldest tap down so the lowest-index match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == src1_addr) begin
                hit1 = src1_used;
                fwd1 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (fwd_valid[i] && fwd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == src2_addr) begin
                hit2 = src2_used;
                fwd2 = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // With two or more writes in flight a forwarded value may be stale.
    always_comb begin
        cnt1        = cnt_q[src1_addr];
        cnt2        = cnt_q[src2_addr];
        hazard1     = src1_used && (cnt1 != '0) && !((cnt1 == CNT_WIDTH'(1)) && hit1);
        hazard2     = src2_used && (cnt2 != '0) && !((cnt2 == CNT_WIDTH'(1)) && hit2);
        full        = dst_used && (cnt_q[dst_addr] == CNT_MAX);
        issue_ready = !hazard1 && !hazard2 && !full && !flush;
        accept      = issue_valid && issue_ready;
        src1_value  = (!hazard1 && hit1) ? fwd1 : rf_src1_value;
        src2_value  = (!hazard2 && hit2) ? fwd2 : rf_src2_value;
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                logic inc, dec;
                inc = accept && dst_used && (dst_addr == ADDR_WIDTH'(r));
                dec = commit_valid && (commit_addr == ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
                if (inc && !dec) begin
                    cnt_q[r] <= cnt_q[r] + CNT_WIDTH'(1);
                end else if (dec && !inc) begin
                    cnt_q[r] <= cnt_q[r] - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (issue_valid && !issue_ready && !flush && stall_count != STALL_MAX) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule
